pulse_edge_transmitter: RTL and testbench
=========================================

Name: pulse_edge_transmitter

Overview:
- Transmit end of the single-bit event interface.
- Converts single-cycle internal event requests into a registered, glitch-free level signal with a guaranteed high phase and low phase. A downstream flop-chain synchronizer plus rising-edge detector, in the same or a slower domain, then sees exactly one rising edge per request.
- Requests arriving while a pulse is in flight are counted and replayed back-to-back. Requests beyond capacity are dropped and flagged.

Parameters:
- HIGH_CYCLES, 4, clk cycles signal_out is held high per event (must be >= 1).
- LOW_CYCLES, 4, clk cycles signal_out is held low after each high phase (must be >= 1). Must cover at least 3 receiver clock periods.
- PEND_W, 3, width of the pending-request counter. Max queued requests = 2^PEND_W - 1.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  event request, one event per cycle high.
- clr_ovf  input  1  clears the sticky overflow flag.
- signal_out  output  1  registered pulse output to the external receiver.
- busy  output  1  high whenever state is not IDLE.
- pending  output  PEND_W  number of queued, not-yet-started events.
- overflow  output  1  sticky: a request was dropped.

Behaviour:
- Reset values: signal_out=0, busy=0, pending=0, overflow=0, state=IDLE, phase counter=0. Reset is asynchronous and applies mid-pulse too: the output drops immediately and queued events are discarded.
- States:
  - IDLE: signal_out=0.
  - HIGH: signal_out=1.
  - LOW: signal_out=0.
- All outputs are driven from flops. No combinational path from req to signal_out.
- Phase counter width is $clog2(max(HIGH_CYCLES, LOW_CYCLES)). It loads on each phase entry and counts down.
- IDLE + req sampled at posedge N → HIGH from posedge N+1. Latency is one cycle.
- HIGH lasts exactly HIGH_CYCLES cycles, then LOW.
- LOW lasts exactly LOW_CYCLES cycles. On its last cycle:
  - if pending>0 or req=1 → HIGH next cycle, with no IDLE gap;
  - else → IDLE.
- Back-to-back rising edges are spaced exactly HIGH_CYCLES+LOW_CYCLES cycles.
- Queue rules:
  - req while busy and not on the LOW-exit cycle → pending+1.
  - LOW-exit with pending>0 and no req → pending-1.
  - LOW-exit with pending>0 and req → pending unchanged.
  - LOW-exit with pending=0 and req → req starts the next pulse directly and pending stays 0.
  - In IDLE, pending is always 0.
- Saturation: req when pending = 2^PEND_W-1 and no simultaneous decrement → request dropped, overflow=1 next cycle, pending unchanged.
- overflow is cleared by clr_ovf (takes effect next cycle). If an overflow event occurs in the same cycle as clr_ovf, set wins.
- Elaboration assertions: HIGH_CYCLES>=1, LOW_CYCLES>=1, PEND_W>=1.

Decomposition:
- Shared package pulse_tx_pkg holds:
  - typedef enum tx_state_t {TX_IDLE, TX_HIGH, TX_LOW};
  - default constants for HIGH_CYCLES, LOW_CYCLES, PEND_W.
- One natural sub-module: sat_updown_counter, the pending counter. It has inc/dec inputs, a saturate flag output, and width parameter PEND_W. The FSM and phase counter stay in the top module.

Test Plan:
Bench uses HIGH_CYCLES=4, LOW_CYCLES=4, PEND_W=2 (max 3). signal_out is also looped into a 3-flop synchronizer plus rising-edge detector model, which must count one edge per accepted request.
- Single event: req at cycle 10 → signal_out=1 cycles 11–14, 0 cycles 15–18; busy=1 cycles 11–18; busy=0 at 19; pending stays 0.
- Queued event: req at cycles 10 and 12 → pending=1 at 13; second rising edge at cycle 19; pending=0 at 19; busy through 26; model counts 2 edges.
- Overflow: req every cycle 10–14 → pending=3 after cycle 13; req at 14 dropped, overflow=1 at 15, pending stays 3; rising edges at 11, 19, 27, 35; model counts 4 edges.
- LOW-exit coincidence: single req at 10, second req at 18 (last LOW cycle) → rising edge at 19 with no IDLE cycle; pending remains 0.
- Reset mid-pulse: rst asserted during cycle 13 (HIGH) → signal_out, busy, pending, overflow read 0 before the next edge. After release, req → normal 4-high/4-low pulse with 1-cycle latency.
- Flag priority: clr_ovf while overflow=1 and no drop → overflow=0 next cycle; clr_ovf in the same cycle as a dropped req → overflow stays 1.

Source files
------------

// File: rtl/pulse_edge_transmitter_pkg.sv
// Shared types and defaults for the pulse edge transmitter slice.
package pulse_tx_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;

  localparam int unsigned DEF_HIGH_CYCLES = 4;
  localparam int unsigned DEF_LOW_CYCLES  = 4;
  localparam int unsigned DEF_PEND_W      = 3;

  // Phase counter must hold the longer of the two phases minus one; never narrower than 1 bit.
  function automatic int unsigned phase_width(input int unsigned high_c, input int unsigned low_c);
    int unsigned m;
    m = (high_c > low_c) ? high_c : low_c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pulse_edge_transmitter_if.sv
// Event request / pulse output bundle between an event source and the transmitter.
interface pulse_edge_transmitter_if
  import pulse_tx_pkg::*;
#(
  parameter int unsigned PEND_W = DEF_PEND_W
);

  logic              req;
  logic              clr_ovf;
  logic              signal_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output req, clr_ovf,
    input  signal_out, busy, pending, overflow
  );

  modport slave (
    input  req, clr_ovf,
    output signal_out, busy, pending, overflow
  );

endinterface

// File: rtl/pulse_edge_transmitter_sat_updown_counter.sv
// Saturating up/down counter holding the number of queued, not-yet-started events.
module sat_updown_counter
  import pulse_tx_pkg::*;
#(
  parameter int unsigned PEND_W = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] count_o,
  output logic              sat_o
);

  logic [PEND_W-1:0] count_q, count_d;

  assign sat_o   = (count_q == '1);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !sat_o)
      count_d = count_q + 1'b1;
    else if (dec_i && !inc_i && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/pulse_edge_transmitter.sv
// Turns single-cycle event requests into fixed-width high/low pulses on a registered
// level output; requests during a pulse are queued and replayed back-to-back.
module pulse_edge_transmitter
  import pulse_tx_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int unsigned LOW_CYCLES  = DEF_LOW_CYCLES,
  parameter int unsigned PEND_W      = DEF_PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  pulse_edge_transmitter_if.slave  bus
);

  localparam int unsigned PH_W = phase_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [PH_W-1:0] HIGH_LOAD = PH_W'(HIGH_CYCLES - 1);
  localparam logic [PH_W-1:0] LOW_LOAD  = PH_W'(LOW_CYCLES - 1);

  if (HIGH_CYCLES == 0) begin : g_bad_high
    $error("HIGH_CYCLES must be >= 1");
  end
  if (LOW_CYCLES == 0) begin : g_bad_low
    $error("LOW_CYCLES must be >= 1");
  end
  if (PEND_W == 0) begin : g_bad_pend
    $error("PEND_W must be >= 1");
  end

  tx_state_t         state_q;
  logic [PH_W-1:0]   phase_q;
  logic              signal_q;
  logic              busy_q;
  logic              overflow_q;

  logic              phase_done;
  logic              low_exit;
  logic              pend_inc;
  logic              pend_dec;
  logic              pend_sat;
  logic              pend_nz;
  logic [PEND_W-1:0] pend_cnt;

  assign phase_done = (phase_q == '0);
  assign low_exit   = (state_q == TX_LOW) && phase_done;
  assign pend_nz    = (pend_cnt != '0);

  // On the LOW-exit cycle a new req starts the next pulse directly instead of queueing.
  assign pend_inc = busy_q && bus.req && !low_exit;
  assign pend_dec = low_exit && pend_nz && !bus.req;

  sat_updown_counter #(
    .PEND_W (PEND_W)
  ) u_pending (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (pend_inc),
    .dec_i   (pend_dec),
    .count_o (pend_cnt),
    .sat_o   (pend_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      phase_q    <= '0;
      signal_q   <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (pend_inc && pend_sat)
        overflow_q <= 1'b1;
      else if (bus.clr_ovf)
        overflow_q <= 1'b0;

      case (state_q)
        TX_IDLE: begin
          if (bus.req) begin
            state_q  <= TX_HIGH;
            phase_q  <= HIGH_LOAD;
            signal_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        TX_HIGH: begin
          if (phase_done) begin
            state_q  <= TX_LOW;
            phase_q  <= LOW_LOAD;
            signal_q <= 1'b0;
          end else begin
            phase_q  <= phase_q - 1'b1;
          end
        end
        TX_LOW: begin
          if (phase_done) begin
            if (pend_nz || bus.req) begin
              state_q  <= TX_HIGH;
              phase_q  <= HIGH_LOAD;
              signal_q <= 1'b1;
            end else begin
              state_q  <= TX_IDLE;
              busy_q   <= 1'b0;
            end
          end else begin
            phase_q  <= phase_q - 1'b1;
          end
        end
        default: begin
          state_q  <= TX_IDLE;
          phase_q  <= '0;
          signal_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.signal_out = signal_q;
  assign bus.busy       = busy_q;
  assign bus.pending    = pend_cnt;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_edge_transmitter.sv
// Bench for pulse_edge_transmitter: scheduled-edge timeline model plus a receiver-side synchronizer/edge counter.
module tb_pulse_edge_transmitter;

  localparam int H    = 4;
  localparam int L    = 4;
  localparam int PW   = 2;
  localparam int P    = H + L;
  localparam int MAXQ = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_edge_transmitter_if #(.PEND_W(PW)) bus ();

  pulse_edge_transmitter #(
    .HIGH_CYCLES (H),
    .LOW_CYCLES  (L),
    .PEND_W      (PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int edges[$];
  bit ovf_m  = 1'b0;
  int accepted = 0;

  // Receiver model: 3-flop synchronizer plus rising-edge counter.
  logic [2:0] sync_q;
  int det_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 3'b000;
    else begin
      sync_q <= {sync_q[1:0], bus.signal_out};
      if (sync_q[1] && !sync_q[2]) det_cnt <= det_cnt + 1;
    end
  end

  function automatic int m_pend();
    int n = 0;
    foreach (edges[k]) if (edges[k] > cyc) n++;
    return n;
  endfunction

  function automatic bit m_sig();
    foreach (edges[k]) if (edges[k] <= cyc && cyc < edges[k] + H) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    foreach (edges[k]) if (edges[k] <= cyc && cyc < edges[k] + P) return 1'b1;
    return 1'b0;
  endfunction

  // Each accepted request owns one rising edge, no earlier than the next cycle and
  // at least one full period after the previous edge.
  task automatic drive(input bit r, input bit c);
    int e, last, n;
    bit drop;
    drop = 1'b0;
    if (r) begin
      last = (edges.size() > 0) ? edges[edges.size()-1] : -P;
      e = (cyc + 1 > last + P) ? cyc + 1 : last + P;
      n = (e > cyc + 1) ? 1 : 0;
      foreach (edges[k]) if (edges[k] > cyc + 1) n++;
      if (n > MAXQ) drop = 1'b1;
      else begin
        edges.push_back(e);
        accepted++;
      end
    end
    if (drop) ovf_m = 1'b1;
    else if (c) ovf_m = 1'b0;
    bus.req = r;
    bus.clr_ovf = c;
    @(posedge clk);
    #1;
    cyc++;
    bus.req = 1'b0;
    bus.clr_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.signal_out !== 1'b0) begin n_fail++; $display("FAIL reset signal_out: got %b exp 0", bus.signal_out); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b exp 0", bus.busy); end
    n_chk++; if (bus.pending !== 2'd0) begin n_fail++; $display("FAIL reset pending: got %0d exp 0", bus.pending); end
    n_chk++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset overflow: got %b exp 0", bus.overflow); end
    rst = 1'b0;
    edges.delete();
    ovf_m = 1'b0;
    repeat (3) drive(1'b0, 1'b0);
  endtask

  task automatic test_single();
    int d0 = det_cnt, a0 = accepted;
    for (int i = 0; i < 20; i++) begin
      drive(i == 0, 1'b0);
      n_chk++; if (bus.signal_out !== m_sig()) begin n_fail++; $display("FAIL single signal_out @%0d: got %b exp %b", cyc, bus.signal_out, m_sig()); end
      n_chk++; if (bus.busy !== m_busy()) begin n_fail++; $display("FAIL single busy @%0d: got %b exp %b", cyc, bus.busy, m_busy()); end
      n_chk++; if (int'(bus.pending) !== m_pend()) begin n_fail++; $display("FAIL single pending @%0d: got %0d exp %0d", cyc, bus.pending, m_pend()); end
      if (i == 0) begin n_chk++; if (bus.signal_out !== 1'b1) begin n_fail++; $display("FAIL single latency: got %b exp 1", bus.signal_out); end end
      if (i == 4) begin n_chk++; if (bus.signal_out !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single low phase: got sig=%b busy=%b exp sig=0 busy=1", bus.signal_out, bus.busy); end end
      if (i == 8) begin n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single idle: got busy=%b exp 0", bus.busy); end end
    end
    n_chk++; if (det_cnt - d0 !== accepted - a0) begin n_fail++; $display("FAIL single edges: got %0d exp %0d", det_cnt - d0, accepted - a0); end
  endtask

  task automatic test_queued();
    int d0 = det_cnt, a0 = accepted;
    for (int i = 0; i < 24; i++) begin
      drive(i == 0 || i == 2, 1'b0);
      n_chk++; if (bus.signal_out !== m_sig()) begin n_fail++; $display("FAIL queued signal_out @%0d: got %b exp %b", cyc, bus.signal_out, m_sig()); end
      n_chk++; if (bus.busy !== m_busy()) begin n_fail++; $display("FAIL queued busy @%0d: got %b exp %b", cyc, bus.busy, m_busy()); end
      n_chk++; if (int'(bus.pending) !== m_pend()) begin n_fail++; $display("FAIL queued pending @%0d: got %0d exp %0d", cyc, bus.pending, m_pend()); end
      if (i == 2) begin n_chk++; if (bus.pending !== 2'd1) begin n_fail++; $display("FAIL queued pend1: got %0d exp 1", bus.pending); end end
      if (i == 8) begin n_chk++; if (bus.signal_out !== 1'b1 || bus.pending !== 2'd0) begin n_fail++; $display("FAIL queued second edge: got sig=%b pend=%0d exp sig=1 pend=0", bus.signal_out, bus.pending); end end
      if (i == 15) begin n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL queued busy end: got %b exp 1", bus.busy); end end
      if (i == 16) begin n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL queued idle: got %b exp 0", bus.busy); end end
    end
    n_chk++; if (det_cnt - d0 !== 2 || accepted - a0 !== 2) begin n_fail++; $display("FAIL queued edges: got %0d exp 2", det_cnt - d0); end
  endtask

  task automatic test_overflow();
    int d0 = det_cnt;
    for (int i = 0; i < 42; i++) begin
      drive(i <= 4, 1'b0);
      n_chk++; if (bus.signal_out !== m_sig()) begin n_fail++; $display("FAIL overflow signal_out @%0d: got %b exp %b", cyc, bus.signal_out, m_sig()); end
      n_chk++; if (bus.busy !== m_busy()) begin n_fail++; $display("FAIL overflow busy @%0d: got %b exp %b", cyc, bus.busy, m_busy()); end
      n_chk++; if (int'(bus.pending) !== m_pend()) begin n_fail++; $display("FAIL overflow pending @%0d: got %0d exp %0d", cyc, bus.pending, m_pend()); end
      n_chk++; if (bus.overflow !== ovf_m) begin n_fail++; $display("FAIL overflow flag @%0d: got %b exp %b", cyc, bus.overflow, ovf_m); end
      if (i == 3) begin n_chk++; if (bus.pending !== 2'd3) begin n_fail++; $display("FAIL overflow full: got %0d exp 3", bus.pending); end end
      if (i == 4) begin n_chk++; if (bus.overflow !== 1'b1 || bus.pending !== 2'd3) begin n_fail++; $display("FAIL overflow drop: got ovf=%b pend=%0d exp ovf=1 pend=3", bus.overflow, bus.pending); end end
      if (i == 24) begin n_chk++; if (bus.signal_out !== 1'b1) begin n_fail++; $display("FAIL overflow fourth edge: got %b exp 1", bus.signal_out); end end
    end
    n_chk++; if (det_cnt - d0 !== 4) begin n_fail++; $display("FAIL overflow edges: got %0d exp 4", det_cnt - d0); end
  endtask

  task automatic test_reset_midpulse();
    int d0, a0;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    n_chk++; if (bus.signal_out !== 1'b1) begin n_fail++; $display("FAIL rstmid pre-high: got %b exp 1", bus.signal_out); end
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (bus.signal_out !== 1'b0) begin n_fail++; $display("FAIL rstmid signal_out: got %b exp 0", bus.signal_out); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid busy: got %b exp 0", bus.busy); end
    n_chk++; if (bus.pending !== 2'd0) begin n_fail++; $display("FAIL rstmid pending: got %0d exp 0", bus.pending); end
    n_chk++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid overflow: got %b exp 0", bus.overflow); end
    edges.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    repeat (4) drive(1'b0, 1'b0);
    d0 = det_cnt;
    a0 = accepted;
    for (int i = 0; i < 14; i++) begin
      drive(i == 0, 1'b0);
      n_chk++; if (bus.signal_out !== m_sig()) begin n_fail++; $display("FAIL rstmid signal_out @%0d: got %b exp %b", cyc, bus.signal_out, m_sig()); end
      n_chk++; if (bus.busy !== m_busy()) begin n_fail++; $display("FAIL rstmid busy @%0d: got %b exp %b", cyc, bus.busy, m_busy()); end
      if (i == 0) begin n_chk++; if (bus.signal_out !== 1'b1) begin n_fail++; $display("FAIL rstmid latency: got %b exp 1", bus.signal_out); end end
    end
    n_chk++; if (det_cnt - d0 !== accepted - a0) begin n_fail++; $display("FAIL rstmid edges: got %0d exp %0d", det_cnt - d0, accepted - a0); end
  endtask

  task automatic test_flag_priority();
    for (int i = 0; i < 42; i++) begin
      drive(i <= 5, i == 5 || i == 6);
      n_chk++; if (bus.overflow !== ovf_m) begin n_fail++; $display("FAIL flag overflow @%0d: got %b exp %b", cyc, bus.overflow, ovf_m); end
      n_chk++; if (int'(bus.pending) !== m_pend()) begin n_fail++; $display("FAIL flag pending @%0d: got %0d exp %0d", cyc, bus.pending, m_pend()); end
      if (i == 5) begin n_chk++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL flag set-wins: got %b exp 1", bus.overflow); end end
      if (i == 6) begin n_chk++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL flag clear: got %b exp 0", bus.overflow); end end
    end
  endtask

  task automatic test_low_exit();
    int d0 = det_cnt;
    for (int i = 0; i < 22; i++) begin
      drive(i == 0 || i == 8, 1'b0);
      n_chk++; if (bus.signal_out !== m_sig()) begin n_fail++; $display("FAIL lowexit signal_out @%0d: got %b exp %b", cyc, bus.signal_out, m_sig()); end
      n_chk++; if (bus.busy !== m_busy()) begin n_fail++; $display("FAIL lowexit busy @%0d: got %b exp %b", cyc, bus.busy, m_busy()); end
      n_chk++; if (int'(bus.pending) !== m_pend()) begin n_fail++; $display("FAIL lowexit pending @%0d: got %0d exp %0d", cyc, bus.pending, m_pend()); end
      if (i == 8) begin n_chk++; if (bus.signal_out !== 1'b1 || bus.busy !== 1'b1 || bus.pending !== 2'd0) begin n_fail++; $display("FAIL lowexit direct: got sig=%b busy=%b pend=%0d exp 1 1 0", bus.signal_out, bus.busy, bus.pending); end end
    end
    n_chk++; if (det_cnt - d0 !== 2) begin n_fail++; $display("FAIL lowexit edges: got %0d exp 2", det_cnt - d0); end
  endtask

  task automatic test_random();
    int d0 = det_cnt, a0 = accepted;
    int thr;
    for (int i = 0; i < 640; i++) begin
      thr = (i < 600) ? ((i / 100) % 3 == 0 ? 15 : ((i / 100) % 3 == 1 ? 50 : 90)) : 0;
      drive($urandom_range(0, 99) < thr, $urandom_range(0, 9) == 0);
      n_chk++; if (bus.signal_out !== m_sig()) begin n_fail++; $display("FAIL random signal_out @%0d: got %b exp %b", cyc, bus.signal_out, m_sig()); end
      n_chk++; if (bus.busy !== m_busy()) begin n_fail++; $display("FAIL random busy @%0d: got %b exp %b", cyc, bus.busy, m_busy()); end
      n_chk++; if (int'(bus.pending) !== m_pend()) begin n_fail++; $display("FAIL random pending @%0d: got %0d exp %0d", cyc, bus.pending, m_pend()); end
      n_chk++; if (bus.overflow !== ovf_m) begin n_fail++; $display("FAIL random overflow @%0d: got %b exp %b", cyc, bus.overflow, ovf_m); end
    end
    n_chk++; if (det_cnt - d0 !== accepted - a0) begin n_fail++; $display("FAIL random edges: got %0d exp %0d", det_cnt - d0, accepted - a0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queued();
    test_overflow();
    test_reset_midpulse();
    repeat (3) drive(1'b0, 1'b0);
    test_flag_priority();
    repeat (3) drive(1'b0, 1'b1);
    test_low_exit();
    repeat (3) drive(1'b0, 1'b0);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
